// File: rtl/fault_injection_ctrl_if.sv
// Command and saboteur-control bundle between the fault-campaign host and
// fault_injection_ctrl. The host side uses the master modport; the
// controller uses the slave modport.
interface fault_injection_ctrl_if #(
  parameter int N_SAB = 16,
  parameter int CNT_W = 16
);
  localparam int IDX_W = (N_SAB > 1) ? $clog2(N_SAB) : 1;

  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] target;
  logic [1:0]       ftype;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] duration;
  logic             abort;
  logic [N_SAB-1:0] en;
  logic [1:0]       ctrl;
  logic             busy;
  logic             done;
  logic             err;
  logic [15:0]      inj_count;

  modport master (
    output valid, target, ftype, delay, duration, abort,
    input  ready, en, ctrl, busy, done, err, inj_count
  );

  modport slave (
    input  valid, target, ftype, delay, duration, abort,
    output ready, en, ctrl, busy, done, err, inj_count
  );
endinterface

// File: rtl/fault_injection_ctrl.sv
// Fault-campaign controller: takes one injection command at a time, waits
// the programmed delay, then enables exactly one saboteur with the
// commanded fault type for the programmed duration (0 = until abort).
// N_SAB and CNT_W must match the parameters of the connected interface.
module fault_injection_ctrl #(
  parameter int N_SAB = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fault_injection_ctrl_if.slave bus
);
  localparam int IDX_W = (N_SAB > 1) ? $clog2(N_SAB) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] INJECT = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dur;
  logic [IDX_W-1:0] tgt;
  logic             accept;
  logic             bad_target;
  logic [N_SAB-1:0] tgt_onehot;

  // An abort in flight blocks acceptance so it can never be mistaken for a
  // command start in the same cycle.
  assign bus.ready  = (state == IDLE) & ~bus.abort;
  assign accept     = bus.valid & bus.ready;
  // Widened compare: with a power-of-two bank the index can never be out of
  // range, but with e.g. 12 saboteurs indices 12..15 must be rejected.
  assign bad_target = 32'(bus.target) >= 32'(N_SAB);
  assign bus.busy   = (state != IDLE);
  assign tgt_onehot = N_SAB'(1) << tgt;

  // Command sequencing: IDLE -> WAIT (delay countdown) -> INJECT (duration
  // countdown or permanent) -> IDLE, with abort overriding everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dur           <= '0;
      tgt           <= '0;
      bus.en        <= '0;
      bus.ctrl      <= 2'b00;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.inj_count <= 16'd0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        bus.en <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (bad_target) begin
                bus.err <= 1'b1;
              end else begin
                tgt      <= bus.target;
                dur      <= bus.duration;
                cnt      <= bus.delay;
                bus.ctrl <= bus.ftype;
                state    <= WAIT;
              end
            end
          end
          WAIT: begin
            if (cnt == '0) begin
              state  <= INJECT;
              cnt    <= dur;
              bus.en <= tgt_onehot;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          INJECT: begin
            if (dur != '0) begin
              if (cnt == CNT_W'(1)) begin
                state    <= IDLE;
                bus.en   <= '0;
                bus.done <= 1'b1;
                if (bus.inj_count != 16'hFFFF) begin
                  bus.inj_count <= bus.inj_count + 16'd1;
                end
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          default: begin
            state  <= IDLE;
            bus.en <= '0;
          end
        endcase
      end
    end
  end
endmodule
